// File: rtl/c2p_pkg.sv
// rtl/c2p_pkg.sv - Shared types, default sizes and map-entry helpers for the polar remapper
package c2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAP_RD = 2'd1,
        PIX_RD = 2'd2,
        EMIT   = 2'd3
    } c2p_state_e;

    localparam int unsigned C2P_MDIM       = 64;
    localparam int unsigned C2P_NO_ARM_LED = 32;
    localparam int unsigned C2P_NO_DELTA   = 180;
    localparam int unsigned C2P_RGB_SIZE   = 24;
    localparam int unsigned C2P_COORD_W    = 8;

    localparam int unsigned C2P_PIX_AW = $clog2(C2P_MDIM * C2P_MDIM);
    localparam int unsigned C2P_MAP_AW = $clog2(C2P_NO_ARM_LED * C2P_NO_DELTA);
    localparam int unsigned C2P_LED_W  = $clog2(C2P_NO_ARM_LED);
    localparam int unsigned C2P_ANG_W  = $clog2(C2P_NO_DELTA);

    // Map entries are {y, x}; coordinate width is passed in so any COORD_W up to 16 works.
    function automatic logic [31:0] map_pack(input logic [15:0] y, input logic [15:0] x,
                                             input int unsigned cw);
        return (32'(y) << cw) | 32'(x);
    endfunction

    function automatic logic [15:0] map_x(input logic [31:0] w, input int unsigned cw);
        return 16'(w & ((32'd1 << cw) - 32'd1));
    endfunction

    function automatic logic [15:0] map_y(input logic [31:0] w, input int unsigned cw);
        return 16'((w >> cw) & ((32'd1 << cw) - 32'd1));
    endfunction

endpackage

// File: rtl/polar_remap_stream_if.sv
// rtl/polar_remap_stream_if.sv - Write ports, column request and pixel stream of the remapper
interface polar_remap_stream_if
    import c2p_pkg::*;
#(
    parameter int unsigned MDIM               = C2P_MDIM,
    parameter int unsigned NO_ARM_LED         = C2P_NO_ARM_LED,
    parameter int unsigned NO_DELTA_INTERVALS = C2P_NO_DELTA,
    parameter int unsigned RGB_SIZE           = C2P_RGB_SIZE,
    parameter int unsigned COORD_W            = C2P_COORD_W
) ();
    localparam int unsigned PIX_AW = $clog2(MDIM * MDIM);
    localparam int unsigned MAP_AW = $clog2(NO_ARM_LED * NO_DELTA_INTERVALS);
    localparam int unsigned LED_W  = $clog2(NO_ARM_LED);
    localparam int unsigned ANG_W  = $clog2(NO_DELTA_INTERVALS);

    logic                   pix_we;
    logic [PIX_AW-1:0]      pix_waddr;
    logic [RGB_SIZE-1:0]    pix_wdata;
    logic                   map_we;
    logic [MAP_AW-1:0]      map_waddr;
    logic [2*COORD_W-1:0]   map_wdata;
    logic                   req_valid;
    logic                   req_ready;
    logic [ANG_W-1:0]       req_angle;
    logic                   out_valid;
    logic                   out_ready;
    logic [RGB_SIZE-1:0]    out_rgb;
    logic [LED_W-1:0]       out_led;
    logic                   out_last;

    modport master (
        output pix_we, pix_waddr, pix_wdata, map_we, map_waddr, map_wdata,
               req_valid, req_angle, out_ready,
        input  req_ready, out_valid, out_rgb, out_led, out_last
    );

    modport slave (
        input  pix_we, pix_waddr, pix_wdata, map_we, map_waddr, map_wdata,
               req_valid, req_angle, out_ready,
        output req_ready, out_valid, out_rgb, out_led, out_last
    );

endinterface

// File: rtl/c2p_sdp_ram.sv
// rtl/c2p_sdp_ram.sv - Simple dual-port RAM, synchronous read-first read port, no reset
module c2p_sdp_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // rdata only moves when re is high, so it doubles as the capture register downstream.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/polar_remap_stream.sv
// rtl/polar_remap_stream.sv - Streaming Cartesian-to-polar column remapper for the LED arm
module polar_remap_stream
    import c2p_pkg::*;
#(
    parameter int unsigned MDIM               = C2P_MDIM,
    parameter int unsigned NO_ARM_LED         = C2P_NO_ARM_LED,
    parameter int unsigned NO_DELTA_INTERVALS = C2P_NO_DELTA,
    parameter int unsigned RGB_SIZE           = C2P_RGB_SIZE,
    parameter int unsigned COORD_W            = C2P_COORD_W,
    parameter logic [RGB_SIZE-1:0] BLANK_RGB  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 busy,
    polar_remap_stream_if.slave  bus
);
    localparam int unsigned PIX_DEPTH = MDIM * MDIM;
    localparam int unsigned MAP_DEPTH = NO_ARM_LED * NO_DELTA_INTERVALS;
    localparam int unsigned PIX_AW    = $clog2(PIX_DEPTH);
    localparam int unsigned MAP_AW    = $clog2(MAP_DEPTH);
    localparam int unsigned LED_W     = $clog2(NO_ARM_LED);
    localparam int unsigned ANG_W     = $clog2(NO_DELTA_INTERVALS);

    c2p_state_e           state_q, state_d;
    logic [ANG_W-1:0]     angle_q, angle_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic                 oob_q, oob_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 req_ready_q, req_ready_d;

    logic                 angle_oob;
    logic                 pix_oob;
    logic [15:0]          ent_x, ent_y;
    logic [MAP_AW-1:0]    map_raddr;
    logic [PIX_AW-1:0]    pix_raddr;
    logic [2*COORD_W-1:0] map_rdata;
    logic [RGB_SIZE-1:0]  pix_rdata;
    logic                 map_re, pix_re;

    assign map_re = (state_q == MAP_RD);
    assign pix_re = (state_q == PIX_RD);

    // Out-of-range angles and coordinates are forced to address 0 so no RAM index ever leaves its depth.
    always_comb begin
        angle_oob = 32'(angle_q) >= NO_DELTA_INTERVALS;
        map_raddr = angle_oob ? '0
                  : MAP_AW'(32'(angle_q) * NO_ARM_LED + 32'(led_q));
        ent_x     = map_x(32'(map_rdata), COORD_W);
        ent_y     = map_y(32'(map_rdata), COORD_W);
        pix_oob   = (32'(ent_x) >= MDIM) || (32'(ent_y) >= MDIM) || angle_oob;
        pix_raddr = pix_oob ? '0
                  : PIX_AW'(32'(ent_y) * MDIM + 32'(ent_x));
    end

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        led_d   = led_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    angle_d = bus.req_angle;
                    led_d   = '0;
                    state_d = MAP_RD;
                end
            end
            MAP_RD: state_d = PIX_RD;
            PIX_RD: begin
                oob_d   = pix_oob;
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        led_d   = led_q + 1'b1;
                        state_d = MAP_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == EMIT);
        out_last_d  = (state_d == EMIT) && (32'(led_d) == NO_ARM_LED - 1);
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            angle_q     <= '0;
            led_q       <= '0;
            oob_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            led_q       <= led_d;
            oob_q       <= oob_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    c2p_sdp_ram #(
        .DEPTH (MAP_DEPTH),
        .WIDTH (2 * COORD_W),
        .AW    (MAP_AW)
    ) u_map_lut (
        .clk   (clk),
        .we    (bus.map_we),
        .waddr (bus.map_waddr),
        .wdata (bus.map_wdata),
        .re    (map_re),
        .raddr (map_raddr),
        .rdata (map_rdata)
    );

    c2p_sdp_ram #(
        .DEPTH (PIX_DEPTH),
        .WIDTH (RGB_SIZE),
        .AW    (PIX_AW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (bus.pix_we),
        .waddr (bus.pix_waddr),
        .wdata (bus.pix_wdata),
        .re    (pix_re),
        .raddr (pix_raddr),
        .rdata (pix_rdata)
    );

    // Frame RAM output is frozen outside PIX_RD, so a stalled beat keeps its colour.
    assign bus.out_rgb   = !out_valid_q ? '0 : (oob_q ? BLANK_RGB : pix_rdata);
    assign bus.out_valid = out_valid_q;
    assign bus.out_led   = led_q;
    assign bus.out_last  = out_last_q;
    assign bus.req_ready = req_ready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_polar_remap_stream.sv
// tb/tb_polar_remap_stream.sv - Directed table-driven bench for polar_remap_stream
module tb_polar_remap_stream;
    import c2p_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic busy_s, busy_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    polar_remap_stream_if #(.MDIM(5), .NO_ARM_LED(4), .NO_DELTA_INTERVALS(3),
                            .RGB_SIZE(24), .COORD_W(8)) if_s ();
    polar_remap_stream_if if_b ();

    polar_remap_stream #(.MDIM(5), .NO_ARM_LED(4), .NO_DELTA_INTERVALS(3),
                         .RGB_SIZE(24), .COORD_W(8), .BLANK_RGB(24'h0)) dut_s (
        .clk   (clk),
        .reset (reset_n),
        .busy  (busy_s),
        .bus   (if_s)
    );

    polar_remap_stream dut_b (
        .clk   (clk),
        .reset (reset_n),
        .busy  (busy_b),
        .bus   (if_b)
    );

    typedef struct {
        int          angle;
        int          led;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    vec_t        vecs [12];
    logic [23:0] got_rgb  [32];
    int          got_led  [32];
    logic        got_last [32];
    logic [23:0] exp_rgb  [32];
    int          nb, acc_edge, first_edge, last_edge;

    logic [23:0] big_frame [4096];
    int          big_x [32];
    int          big_y [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic request_s(input int ang);
        bit acc;
        acc = 1'b0;
        if_s.req_valid = 1'b1;
        if_s.req_angle = 2'(ang);
        if_s.out_ready = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (if_s.req_ready) begin
                acc_edge = cyc + 1;
                acc      = 1'b1;
            end
            @(negedge clk);
        end
        if_s.req_valid = 1'b0;
        check($sformatf("accept_a%0d", ang), 32'(acc), 32'd1);
    endtask

    // Optional stall on one beat: 5 cycles of out_ready low with two pixel writes inside the stall.
    task automatic run_col(input int ang, input int stall_beat);
        int          st;
        bit          seen;
        logic [23:0] hold_rgb;
        int          hold_led;
        st = 0; seen = 1'b0; nb = 0; first_edge = -1; last_edge = -1;
        hold_rgb = '0; hold_led = 0;
        request_s(ang);
        check($sformatf("req_ready_low_a%0d", ang), 32'(if_s.req_ready), 32'd0);
        check($sformatf("busy_high_a%0d", ang), 32'(busy_s), 32'd1);
        for (int t = 0; t < 200 && nb < 4; t++) begin
            if_s.pix_we = 1'b0;
            if (if_s.out_valid) begin
                if (!seen) begin
                    seen       = 1'b1;
                    first_edge = cyc;
                end
                if (stall_beat >= 0 && int'(if_s.out_led) == stall_beat && st < 6) begin
                    if (st == 0) begin
                        hold_rgb       = if_s.out_rgb;
                        hold_led       = int'(if_s.out_led);
                        if_s.out_ready = 1'b0;
                        if_s.pix_we    = 1'b1;
                        if_s.pix_waddr = 5'd12;
                        if_s.pix_wdata = 24'hAAAAAA;
                    end else begin
                        check($sformatf("stall_rgb_%0d", st), 32'(if_s.out_rgb), 32'(hold_rgb));
                        check($sformatf("stall_led_%0d", st), 32'(if_s.out_led), 32'(hold_led));
                        if (st == 2) begin
                            if_s.pix_we    = 1'b1;
                            if_s.pix_waddr = 5'd24;
                            if_s.pix_wdata = 24'hBBBBBB;
                        end
                    end
                    st++;
                    if (st == 6) if_s.out_ready = 1'b1;
                end
                if (if_s.out_ready) begin
                    got_rgb[nb]  = if_s.out_rgb;
                    got_led[nb]  = int'(if_s.out_led);
                    got_last[nb] = if_s.out_last;
                    nb++;
                    last_edge = cyc + 1;
                end
            end
            @(negedge clk);
        end
        if_s.pix_we = 1'b0;
        check($sformatf("idle_ready_a%0d", ang), 32'(if_s.req_ready), 32'd1);
        check($sformatf("idle_busy_a%0d", ang), 32'(busy_s), 32'd0);
    endtask

    task automatic check_col(input string tag, input int n, input int col_edges);
        check({tag, "_beats"}, 32'(nb), 32'(n));
        check({tag, "_first_valid"}, 32'(first_edge - acc_edge), 32'd2);
        check({tag, "_col_cycles"}, 32'(last_edge - acc_edge), 32'(col_edges));
        for (int b = 0; b < n && b < nb; b++) begin
            check($sformatf("%s_rgb_b%0d", tag, b), 32'(got_rgb[b]), 32'(exp_rgb[b]));
            check($sformatf("%s_led_b%0d", tag, b), 32'(got_led[b]), 32'(b));
            check($sformatf("%s_last_b%0d", tag, b), 32'(got_last[b]), 32'(b == n - 1));
        end
    endtask

    initial begin
        bit acc;
        bit done;

        vecs[0]  = '{0, 0, 1, 0, 24'h01};
        vecs[1]  = '{0, 1, 0, 1, 24'h05};
        vecs[2]  = '{0, 2, 3, 2, 24'h0D};
        vecs[3]  = '{0, 3, 2, 3, 24'h11};
        vecs[4]  = '{1, 0, 0, 0, 24'h00};
        vecs[5]  = '{1, 1, 1, 1, 24'h06};
        vecs[6]  = '{1, 2, 2, 2, 24'h0C};
        vecs[7]  = '{1, 3, 4, 4, 24'h18};
        vecs[8]  = '{2, 0, 5, 0, 24'h00};
        vecs[9]  = '{2, 1, 3, 1, 24'h08};
        vecs[10] = '{2, 2, 0, 7, 24'h00};
        vecs[11] = '{2, 3, 4, 0, 24'h04};

        if_s.pix_we = 1'b0; if_s.pix_waddr = '0; if_s.pix_wdata = '0;
        if_s.map_we = 1'b0; if_s.map_waddr = '0; if_s.map_wdata = '0;
        if_s.req_valid = 1'b0; if_s.req_angle = '0; if_s.out_ready = 1'b1;
        if_b.pix_we = 1'b0; if_b.pix_waddr = '0; if_b.pix_wdata = '0;
        if_b.map_we = 1'b0; if_b.map_waddr = '0; if_b.map_wdata = '0;
        if_b.req_valid = 1'b0; if_b.req_angle = '0; if_b.out_ready = 1'b1;

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(if_s.out_valid), 32'd0);
        check("rst_out_rgb",   32'(if_s.out_rgb),   32'd0);
        check("rst_out_led",   32'(if_s.out_led),   32'd0);
        check("rst_out_last",  32'(if_s.out_last),  32'd0);
        check("rst_busy",      32'(busy_s),         32'd0);
        check("rst_req_ready", 32'(if_s.req_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        check("req_ready_before_edge", 32'(if_s.req_ready), 32'd0);
        @(negedge clk);
        check("req_ready_after_edge", 32'(if_s.req_ready), 32'd1);

        for (int p = 0; p < 25; p++) begin
            if_s.pix_we = 1'b1; if_s.pix_waddr = 5'(p); if_s.pix_wdata = 24'(p);
            @(negedge clk);
        end
        if_s.pix_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if_s.map_we    = 1'b1;
            if_s.map_waddr = 4'(vecs[i].angle * 4 + vecs[i].led);
            if_s.map_wdata = 16'(map_pack(16'(vecs[i].y), 16'(vecs[i].x), 8));
            @(negedge clk);
        end
        if_s.map_we = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 3; a++) begin
            run_col(a, -1);
            for (int b = 0; b < 4; b++) exp_rgb[b] = vecs[a * 4 + b].rgb;
            check_col($sformatf("tbl_a%0d", a), 4, 12);
        end

        run_col(3, -1);
        for (int b = 0; b < 4; b++) exp_rgb[b] = 24'h0;
        check_col("oob_angle", 4, 12);

        run_col(1, 2);
        exp_rgb[0] = 24'h00; exp_rgb[1] = 24'h06; exp_rgb[2] = 24'h0C; exp_rgb[3] = 24'hBBBBBB;
        check_col("stall", 4, 17);

        if_s.pix_we = 1'b1; if_s.pix_waddr = 5'd12; if_s.pix_wdata = 24'h0C;
        @(negedge clk);
        if_s.pix_waddr = 5'd24; if_s.pix_wdata = 24'h18;
        @(negedge clk);
        if_s.pix_we = 1'b0;
        @(negedge clk);

        request_s(1);
        nb = 0; done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (if_s.out_valid) begin
                if (nb == 2) begin
                    reset_n = 1'b0;
                    #1;
                    check("midrst_out_valid", 32'(if_s.out_valid), 32'd0);
                    check("midrst_busy",      32'(busy_s),         32'd0);
                    check("midrst_req_ready", 32'(if_s.req_ready), 32'd0);
                    check("midrst_out_rgb",   32'(if_s.out_rgb),   32'd0);
                    done = 1'b1;
                end else if (if_s.out_ready) begin
                    nb++;
                end
            end
            if (!done) @(negedge clk);
        end
        check("midrst_reached", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check("midrst_held_valid", 32'(if_s.out_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 32'(if_s.req_ready), 32'd1);
        run_col(0, -1);
        for (int b = 0; b < 4; b++) exp_rgb[b] = vecs[b].rgb;
        check_col("after_rst", 4, 12);

        for (int p = 0; p < 4096; p++) begin
            big_frame[p]   = 24'($urandom);
            if_b.pix_we    = 1'b1;
            if_b.pix_waddr = 12'(p);
            if_b.pix_wdata = big_frame[p];
            @(negedge clk);
        end
        if_b.pix_we = 1'b0;
        for (int l = 0; l < 32; l++) begin
            big_x[l] = int'($urandom_range(0, 70));
            big_y[l] = int'($urandom_range(0, 70));
            if (l == 5) begin big_x[l] = 64; big_y[l] = 10; end
            if (l == 6) begin big_x[l] = 10; big_y[l] = 64; end
            if (l == 7) begin big_x[l] = 63; big_y[l] = 63; end
            if_b.map_we    = 1'b1;
            if_b.map_waddr = 13'(179 * 32 + l);
            if_b.map_wdata = 16'(map_pack(16'(big_y[l]), 16'(big_x[l]), 8));
            @(negedge clk);
        end
        if_b.map_we = 1'b0;
        @(negedge clk);

        acc = 1'b0;
        if_b.req_valid = 1'b1; if_b.req_angle = 8'd179; if_b.out_ready = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            if (if_b.req_ready) begin
                acc_edge = cyc + 1;
                acc      = 1'b1;
            end
            @(negedge clk);
        end
        if_b.req_valid = 1'b0;
        check("big_accept", 32'(acc), 32'd1);
        nb = 0; first_edge = -1; last_edge = -1;
        for (int t = 0; t < 400 && nb < 32; t++) begin
            if (if_b.out_valid) begin
                if (first_edge < 0) first_edge = cyc;
                got_rgb[nb]  = if_b.out_rgb;
                got_led[nb]  = int'(if_b.out_led);
                got_last[nb] = if_b.out_last;
                nb++;
                last_edge = cyc + 1;
            end
            @(negedge clk);
        end
        for (int l = 0; l < 32; l++) begin
            exp_rgb[l] = (big_x[l] >= 64 || big_y[l] >= 64) ? 24'h0
                       : big_frame[big_y[l] * 64 + big_x[l]];
        end
        check_col("big", 32, 96);
        check("big_idle_busy", 32'(busy_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
